// File: rtl/hmc_token_flow_ctrl_pkg.sv
// Shared constants and the saturating-add helper for HMC link token accounting.
// Used by the token flow controller and its adder-tree sub-module.
package hmc_flow_pkg;

  localparam int               RTC_W   = 5;
  localparam logic [RTC_W-1:0] RTC_MAX = 5'd31;

  localparam int               LNG_W   = 4;
  localparam logic [LNG_W-1:0] LNG_MIN = 4'd1;
  localparam logic [LNG_W-1:0] LNG_MAX = 4'd9;

  typedef struct packed {
    logic        ovf;
    logic [31:0] val;
  } sat_t;

  // base + inc clamped to lim; ovf flags any result strictly above lim.
  function automatic sat_t sat_add(input logic [31:0] base,
                                   input logic [31:0] inc,
                                   input logic [31:0] lim);
    sat_t        r;
    logic [32:0] s;
    s     = {1'b0, base} + {1'b0, inc};
    r.ovf = (s > {1'b0, lim});
    r.val = r.ovf ? lim : s[31:0];
    return r;
  endfunction

endpackage

// File: rtl/hmc_token_flow_ctrl_sum.sv
// Unregistered adder tree summing N masked W-bit lane values.
// Serves both the returned-RTC sum and, with W=1, the rx_free popcount.
module hmc_token_sum
  import hmc_flow_pkg::*;
#(
  parameter int N  = 4,
  parameter int W  = RTC_W,
  parameter int OW = W + $clog2(N)
) (
  input  logic [N*W-1:0] vals_i,
  input  logic [N-1:0]   mask_i,
  output logic [OW-1:0]  sum_o
);

  logic [OW-1:0] lane_v [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      lane_v[i] = mask_i[i] ? OW'(vals_i[i*W +: W]) : '0;
    end
  end

  // Pairwise reduction: each level halves the number of live partial sums.
  localparam int LVLS = (N > 1) ? $clog2(N) : 1;
  localparam int PADN = 1 << LVLS;

  logic [OW-1:0] tree [LVLS+1][PADN];

  always_comb begin
    for (int l = 0; l <= LVLS; l++) begin
      for (int j = 0; j < PADN; j++) begin
        tree[l][j] = '0;
      end
    end
    for (int j = 0; j < N; j++) begin
      tree[0][j] = lane_v[j];
    end
    for (int l = 0; l < LVLS; l++) begin
      for (int j = 0; j < (PADN >> (l + 1)); j++) begin
        tree[l+1][j] = tree[l][2*j] + tree[l][2*j+1];
      end
    end
  end

  assign sum_o = tree[LVLS][0];

endmodule

// File: rtl/hmc_token_flow_ctrl.sv
// Link-layer token accounting: HMC input-buffer credits gating TX issue and
// local RX-buffer tokens owed back to the HMC through the RTC field.
module hmc_token_flow_ctrl
  import hmc_flow_pkg::*;
#(
  parameter int FPW                = 4,
  parameter int LOG_MAX_HMC_TOKENS = 10,
  parameter int LOG_MAX_RX_TOKENS  = 8
) (
  input  logic                          clk_hmc,
  input  logic                          res_n_hmc,
  input  logic                          load_init,
  input  logic [LOG_MAX_HMC_TOKENS:0]   init_hmc_tokens,
  input  logic [LOG_MAX_RX_TOKENS:0]    init_rx_tokens,
  input  logic                          req_valid,
  input  logic [LNG_W-1:0]              req_flits,
  output logic                          req_ready,
  input  logic [FPW-1:0]                hmc_ret_valid,
  input  logic [FPW*RTC_W-1:0]          hmc_ret_rtc,
  input  logic [FPW-1:0]                rx_free,
  input  logic                          rtc_take,
  output logic [RTC_W-1:0]              rtc_out,
  output logic [LOG_MAX_HMC_TOKENS:0]   hmc_tokens,
  output logic [LOG_MAX_RX_TOKENS:0]    rx_pending,
  output logic                          err_hmc_ovf,
  output logic                          err_rx_ovf,
  output logic                          err_bad_len
);

  localparam int HW = LOG_MAX_HMC_TOKENS + 1;
  localparam int RW = LOG_MAX_RX_TOKENS + 1;
  localparam int CW = LOG_MAX_HMC_TOKENS + 5;
  localparam int SW = RTC_W + $clog2(FPW);
  localparam int PW = 1 + $clog2(FPW);

  localparam logic [31:0] HMC_LIM = 32'(1) << LOG_MAX_HMC_TOKENS;
  localparam logic [31:0] RX_LIM  = 32'(1) << LOG_MAX_RX_TOKENS;

  logic [HW-1:0] hmc_q, hmc_d;
  logic [RW-1:0] rx_q, rx_d;
  logic          err_hmc_q, err_hmc_d;
  logic          err_rx_q, err_rx_d;
  logic          err_len_q, err_len_d;

  logic [SW-1:0] ret_sum;
  logic [PW-1:0] free_cnt;
  logic          len_ok;
  logic          fire;
  logic [CW-1:0] hmc_net;
  logic [RW-1:0] rx_net;
  sat_t          hmc_sat;
  sat_t          rx_sat;
  logic          unused_sat_hi;

  hmc_token_sum #(
    .N (FPW),
    .W (RTC_W)
  ) u_ret_sum (
    .vals_i (hmc_ret_rtc),
    .mask_i (hmc_ret_valid),
    .sum_o  (ret_sum)
  );

  hmc_token_sum #(
    .N (FPW),
    .W (1)
  ) u_free_cnt (
    .vals_i (rx_free),
    .mask_i ({FPW{1'b1}}),
    .sum_o  (free_cnt)
  );

  assign len_ok    = (req_flits >= LNG_MIN) && (req_flits <= LNG_MAX);
  // Only the registered count is consulted; same-cycle credits wait a cycle.
  assign req_ready = (hmc_q >= HW'(req_flits)) && len_ok && !load_init;
  assign fire      = req_valid && req_ready;
  assign rtc_out   = (rx_q > RW'(RTC_MAX)) ? RTC_MAX : rx_q[RTC_W-1:0];

  always_comb begin
    hmc_net = CW'(hmc_q) - (fire ? CW'(req_flits) : CW'(0));
    rx_net  = rx_q - (rtc_take ? RW'(rtc_out) : RW'(0));
    hmc_sat = sat_add(32'(hmc_net), 32'(ret_sum), HMC_LIM);
    rx_sat  = sat_add(32'(rx_net), 32'(free_cnt), RX_LIM);

    if (load_init) begin
      hmc_d     = init_hmc_tokens;
      rx_d      = init_rx_tokens;
      err_hmc_d = 1'b0;
      err_rx_d  = 1'b0;
      err_len_d = 1'b0;
    end else begin
      hmc_d     = hmc_sat.val[HW-1:0];
      rx_d      = rx_sat.val[RW-1:0];
      err_hmc_d = err_hmc_q | hmc_sat.ovf;
      err_rx_d  = err_rx_q | rx_sat.ovf;
      err_len_d = err_len_q | (req_valid & ~len_ok);
    end
  end

  // Clamped results never exceed the limit, so the upper bits are always zero.
  assign unused_sat_hi = ^{hmc_sat.val[31:HW], rx_sat.val[31:RW]};

  always_ff @(posedge clk_hmc or negedge res_n_hmc) begin
    if (!res_n_hmc) begin
      hmc_q     <= '0;
      rx_q      <= '0;
      err_hmc_q <= 1'b0;
      err_rx_q  <= 1'b0;
      err_len_q <= 1'b0;
    end else begin
      hmc_q     <= hmc_d;
      rx_q      <= rx_d;
      err_hmc_q <= err_hmc_d;
      err_rx_q  <= err_rx_d;
      err_len_q <= err_len_d;
    end
  end

  assign hmc_tokens  = hmc_q;
  assign rx_pending  = rx_q;
  assign err_hmc_ovf = err_hmc_q;
  assign err_rx_ovf  = err_rx_q;
  assign err_bad_len = err_len_q;

endmodule

// File: tb/tb_hmc_token_flow_ctrl.sv
// Directed plus randomized bench for hmc_token_flow_ctrl with a behavioral
// counter model feeding an expected-value queue.
module tb_hmc_token_flow_ctrl;

  localparam int FPW  = 4;
  localparam int LOGH = 10;
  localparam int LOGR = 8;
  localparam int HLIM = 1 << LOGH;
  localparam int RLIM = 1 << LOGR;

  logic              clk_hmc;
  logic              res_n_hmc;
  logic              load_init;
  logic [LOGH:0]     init_hmc_tokens;
  logic [LOGR:0]     init_rx_tokens;
  logic              req_valid;
  logic [3:0]        req_flits;
  logic              req_ready;
  logic [FPW-1:0]    hmc_ret_valid;
  logic [FPW*5-1:0]  hmc_ret_rtc;
  logic [FPW-1:0]    rx_free;
  logic              rtc_take;
  logic [4:0]        rtc_out;
  logic [LOGH:0]     hmc_tokens;
  logic [LOGR:0]     rx_pending;
  logic              err_hmc_ovf;
  logic              err_rx_ovf;
  logic              err_bad_len;

  hmc_token_flow_ctrl #(
    .FPW                (FPW),
    .LOG_MAX_HMC_TOKENS (LOGH),
    .LOG_MAX_RX_TOKENS  (LOGR)
  ) dut (
    .clk_hmc         (clk_hmc),
    .res_n_hmc       (res_n_hmc),
    .load_init       (load_init),
    .init_hmc_tokens (init_hmc_tokens),
    .init_rx_tokens  (init_rx_tokens),
    .req_valid       (req_valid),
    .req_flits       (req_flits),
    .req_ready       (req_ready),
    .hmc_ret_valid   (hmc_ret_valid),
    .hmc_ret_rtc     (hmc_ret_rtc),
    .rx_free         (rx_free),
    .rtc_take        (rtc_take),
    .rtc_out         (rtc_out),
    .hmc_tokens      (hmc_tokens),
    .rx_pending      (rx_pending),
    .err_hmc_ovf     (err_hmc_ovf),
    .err_rx_ovf      (err_rx_ovf),
    .err_bad_len     (err_bad_len)
  );

  initial clk_hmc = 1'b0;
  always #5 clk_hmc = ~clk_hmc;

  typedef struct {
    int hmc;
    int rx;
    int eh;
    int er;
    int eb;
  } exp_t;

  exp_t sb_q[$];
  int total = 0;
  int bad   = 0;
  int m_hmc, m_rx, m_eh, m_er, m_eb;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic idle();
    load_init       = 1'b0;
    init_hmc_tokens = '0;
    init_rx_tokens  = '0;
    req_valid       = 1'b0;
    req_flits       = 4'd0;
    hmc_ret_valid   = '0;
    hmc_ret_rtc     = '0;
    rx_free         = '0;
    rtc_take        = 1'b0;
  endtask

  task automatic model_reset();
    m_hmc = 0; m_rx = 0; m_eh = 0; m_er = 0; m_eb = 0;
  endtask

  // Check combinational outputs for the driven inputs, push the model's
  // next-state prediction, clock once, then pop and compare the registers.
  task automatic cycle();
    int   rdy, rtc, h, r, pc, fl;
    exp_t e;
    exp_t got;
    #1;
    fl  = int'(req_flits);
    rtc = (m_rx > 31) ? 31 : m_rx;
    rdy = (!load_init && m_hmc >= fl && fl >= 1 && fl <= 9) ? 1 : 0;
    chk("req_ready", 32'(req_ready), 32'(rdy));
    chk("rtc_out", 32'(rtc_out), 32'(rtc));
    if (load_init) begin
      e.hmc = int'(init_hmc_tokens);
      e.rx  = int'(init_rx_tokens);
      e.eh  = 0; e.er = 0; e.eb = 0;
    end else begin
      h = m_hmc - ((req_valid && rdy != 0) ? fl : 0);
      for (int i = 0; i < FPW; i++)
        if (hmc_ret_valid[i]) h += int'(hmc_ret_rtc[i*5 +: 5]);
      e.eh = m_eh;
      if (h > HLIM) begin h = HLIM; e.eh = 1; end
      pc = 0;
      for (int i = 0; i < FPW; i++) pc += int'(rx_free[i]);
      r = m_rx - (rtc_take ? rtc : 0) + pc;
      e.er = m_er;
      if (r > RLIM) begin r = RLIM; e.er = 1; end
      e.eb  = (req_valid && (fl < 1 || fl > 9)) ? 1 : m_eb;
      e.hmc = h;
      e.rx  = r;
    end
    sb_q.push_back(e);
    @(posedge clk_hmc);
    #1;
    got = sb_q.pop_front();
    chk("hmc_tokens", 32'(hmc_tokens), 32'(got.hmc));
    chk("rx_pending", 32'(rx_pending), 32'(got.rx));
    chk("err_hmc_ovf", 32'(err_hmc_ovf), 32'(got.eh));
    chk("err_rx_ovf", 32'(err_rx_ovf), 32'(got.er));
    chk("err_bad_len", 32'(err_bad_len), 32'(got.eb));
    m_hmc = got.hmc; m_rx = got.rx; m_eh = got.eh; m_er = got.er; m_eb = got.eb;
  endtask

  task automatic load(input int h, input int r);
    idle();
    load_init       = 1'b1;
    init_hmc_tokens = (LOGH+1)'(h);
    init_rx_tokens  = (LOGR+1)'(r);
    cycle();
    idle();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_hmc"}, 32'(hmc_tokens), 32'd0);
    chk({tag, "_rx"}, 32'(rx_pending), 32'd0);
    chk({tag, "_rtc"}, 32'(rtc_out), 32'd0);
    chk({tag, "_rdy"}, 32'(req_ready), 32'd0);
    chk({tag, "_flags"}, 32'({err_hmc_ovf, err_rx_ovf, err_bad_len}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    model_reset();
    res_n_hmc = 1'b0;
    repeat (3) @(posedge clk_hmc);
    #1;
    req_valid = 1'b1;
    req_flits = 4'd1;
    #1;
    chk_all_zero("reset");
    @(posedge clk_hmc);
    #1;
    res_n_hmc = 1'b1;

    // No tokens yet: legal request must stall.
    req_valid = 1'b1; req_flits = 4'd1;
    cycle();
    idle();

    load(20, 40);
    cycle();                       // rtc_out checked at 31 here

    // Grant, debit, stall, credit, grant.
    load(10, 0);
    req_valid = 1'b1; req_flits = 4'd9;
    cycle();
    req_flits = 4'd2;
    hmc_ret_valid = 4'b0001; hmc_ret_rtc = 20'd5;
    cycle();
    hmc_ret_valid = '0; hmc_ret_rtc = '0;
    cycle();
    cycle();
    idle();

    // HMC saturation at 1024.
    load(1000, 0);
    hmc_ret_valid = '1;
    hmc_ret_rtc   = {5'd31, 5'd31, 5'd31, 5'd31};
    cycle();
    idle();
    cycle();

    // Return fewer than owed.
    load(5, 3);
    rtc_take = 1'b1; rx_free = 4'b1011;
    cycle();
    idle();

    // Take while nothing is pending.
    load(5, 0);
    rtc_take = 1'b1; rx_free = 4'b0001;
    cycle();
    rtc_take = 1'b1; rx_free = 4'b0000;
    cycle();
    idle();

    // Illegal lengths, then load clears the flag.
    load(50, 0);
    req_valid = 1'b1; req_flits = 4'd0;
    cycle();
    req_flits = 4'd10;
    cycle();
    idle();
    load(7, 7);

    // RX saturation at 256, then draining by rtc_take.
    load(0, 255);
    rx_free = 4'b1111;
    cycle();
    rtc_take = 1'b1; rx_free = 4'b0011;
    cycle();
    idle();

    // load_init coincident with fire, returns, frees and take.
    load(30, 30);
    load_init = 1'b1; init_hmc_tokens = 11'd77; init_rx_tokens = 9'd12;
    req_valid = 1'b1; req_flits = 4'd3;
    hmc_ret_valid = '1; hmc_ret_rtc = {5'd9, 5'd8, 5'd7, 5'd6};
    rx_free = '1; rtc_take = 1'b1;
    cycle();
    idle();

    // Back-to-back grants each see the reduced count.
    load(12, 0);
    req_valid = 1'b1; req_flits = 4'd5;
    repeat (3) cycle();
    idle();

    // Random traffic.
    for (int k = 0; k < 300; k++) begin
      idle();
      req_valid = 1'($urandom_range(0, 1));
      req_flits = 4'($urandom_range(0, 10));
      for (int i = 0; i < FPW; i++) begin
        hmc_ret_valid[i]       = ($urandom_range(0, 3) == 0);
        hmc_ret_rtc[i*5 +: 5]  = 5'($urandom_range(0, 31));
      end
      rx_free  = FPW'($urandom_range(0, 15));
      rtc_take = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 19) == 0) begin
        load_init       = 1'b1;
        init_hmc_tokens = (LOGH+1)'($urandom_range(0, HLIM));
        init_rx_tokens  = (LOGR+1)'($urandom_range(0, RLIM));
      end
      cycle();
    end
    idle();

    // Asynchronous reset mid-stream.
    load(100, 100);
    req_valid = 1'b1; req_flits = 4'd4; rx_free = 4'b0101;
    cycle();
    #2;
    res_n_hmc = 1'b0;
    #1;
    chk_all_zero("midreset");
    model_reset();
    idle();
    @(posedge clk_hmc);
    #1;
    res_n_hmc = 1'b1;
    req_valid = 1'b1; req_flits = 4'd1;
    cycle();
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hmc_token_flow_ctrl.md
# hmc_token_flow_ctrl

Link-layer token accounting for the openHMC controller, sitting between the TX packet framer and the RX link. It tracks HMC input-buffer tokens, which gate TX packet issue, and local RX-buffer tokens, which are owed back to the HMC through the RTC field of outgoing packets. It replaces ad-hoc counters in the TX path with one checked block of saturating credit/debit arithmetic.

## Interface
- FPW, 4, FLITs per word (2, 4, 6, 8); sets the number of parallel return/free lanes
- LOG_MAX_HMC_TOKENS, 10, log2 of HMC input-buffer depth
- LOG_MAX_RX_TOKENS, 8, log2 of local RX input-buffer depth
- clk_hmc  in  1  link clock; all logic is on this clock
- res_n_hmc  in  1  asynchronous, active-low reset
- load_init  in  1  pulse: load both counters from the init values
- init_hmc_tokens  in  LOG_MAX_HMC_TOKENS+1  initial HMC token count
- init_rx_tokens  in  LOG_MAX_RX_TOKENS+1  initial RX tokens owed to the HMC
- req_valid  in  1  TX framer wants to send one packet
- req_flits  in  4  packet length in FLITs; legal range 1..9
- req_ready  out  1  packet may be sent; the debit happens on req_valid & req_ready
- hmc_ret_valid  in  FPW  per-lane valid for RTC fields received from the HMC
- hmc_ret_rtc  in  FPW*5  per-lane returned-token count, 0..31
- rx_free  in  FPW  per-lane flag: one FLIT left the RX buffer, so one token is owed
- rtc_take  in  1  framer embeds rtc_out into the packet being sent this cycle
- rtc_out  out  5  tokens to embed, min(rx_pending, 31)
- hmc_tokens  out  LOG_MAX_HMC_TOKENS+1  current HMC token count
- rx_pending  out  LOG_MAX_RX_TOKENS+1  RX tokens not yet returned
- err_hmc_ovf  out  1  sticky: HMC count would exceed 2^LOG_MAX_HMC_TOKENS
- err_rx_ovf  out  1  sticky: RX pending would exceed 2^LOG_MAX_RX_TOKENS
- err_bad_len  out  1  sticky: req_valid was asserted with req_flits of 0 or greater than 9

## Operation
- Reset value of all registered outputs is 0, so req_ready is 0 after reset.
- HMC counter update each cycle: next = hmc_tokens − (fire ? req_flits : 0) + Σ(hmc_ret_valid[i] ? hmc_ret_rtc[i] : 0).
  - fire = req_valid & req_ready.
  - Compute in LOG_MAX_HMC_TOKENS+5 bits.
  - If the result exceeds 2^LOG_MAX_HMC_TOKENS, saturate to 2^LOG_MAX_HMC_TOKENS and set err_hmc_ovf.
- req_ready = (hmc_tokens ≥ req_flits) & (req_flits ∈ 1..9) & !load_init.
  - Combinational from the registered count and req_flits.
  - Credits arriving in the same cycle are not usable until the next cycle.
- An illegal req_flits with req_valid high sets err_bad_len and is never granted.
- RX counter update each cycle: next = rx_pending − (rtc_take ? rtc_out : 0) + popcount(rx_free).
  - Saturate at 2^LOG_MAX_RX_TOKENS and set err_rx_ovf on overflow.
- rtc_take while rx_pending is 0: rtc_out is 0 and the counter is unchanged apart from rx_free.
- load_init has priority over every other input in its cycle.
  - Counters take the init values; debits, credits and frees in that cycle are discarded.
  - All err_* flags clear.
- There is no state machine beyond the two counters and the flags. Deassertion of req_valid without a grant is legal.

## Timing
- Credit to visibility: hmc_ret or rx_free in cycle N appears on hmc_tokens / rx_pending in cycle N+1.
- Grant to debit: a fire in cycle N reduces hmc_tokens in cycle N+1. A back-to-back grant in N+1 sees the reduced count.
- rtc_out is combinational from the rx_pending register and is stable for the whole cycle.
- Reset asserted mid-operation clears all state immediately. After deassertion, req_ready stays 0 until load_init or returned tokens arrive.
- Worst-case path is the FPW-input 5-bit adder tree followed by compare and saturate; it must close at clk_hmc with FPW=8.

## Structure
- Package hmc_flow_pkg holds the shared constants:
  - RTC_W = 5, RTC_MAX = 31, LNG_MIN = 1, LNG_MAX = 9
  - saturating-add function
- One sub-module, hmc_token_sum: registered-free adder tree summing FPW masked 5-bit values. It is reused for the rx_free popcount, with 1-bit inputs zero-extended.

## Test plan
- Reset, then load_init with init_hmc_tokens=20 and init_rx_tokens=40 -> hmc_tokens=20 and rx_pending=40 next cycle; rtc_out=31.
- hmc_tokens=10 with req_flits=9 granted, then req_flits=2 the next cycle -> first grant fires, hmc_tokens=1, second request stalls with req_ready=0. hmc_ret_rtc lane0=5 -> request is granted one cycle after the credit lands.
- FPW=4, all lanes returning 31 with hmc_tokens=1000 (LOG=10) -> hmc_tokens saturates at 1024 and err_hmc_ovf=1.
- rx_pending=3, rtc_take together with rx_free=4'b1011 -> rtc_out=3, rx_pending=3 next cycle.
- req_valid with req_flits=0 -> req_ready=0, err_bad_len=1, hmc_tokens unchanged. A subsequent load_init clears the flag.
- load_init coincident with a fire and returns -> counters equal the init values exactly; reset asserted mid-stream -> all outputs 0 immediately.
